delay_sched: RTL and testbench

Shared delay-timer scheduler. NREQ requesters each ask for a programmable delay of LEN cycles. One down-counter is time-shared between them by a round-robin arbiter. The winner holds a grant while its delay runs and receives a one-cycle done pulse when the delay expires. It sits in front of the timing/delay datapath so that several control blocks can share a single wide counter instead of each owning one.

---
 rtl/delay_sched_pkg.sv | 35 +++
 rtl/delay_sched_if.sv | 31 +++
 rtl/delay_rr_pick.sv | 50 +++++
 rtl/delay_sched.sv | 143 ++++++++++++++
 tb/tb_delay_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/delay_sched_pkg.sv
// ---------------------------------------------------------------------------
// delay_sched_pkg
// Shared types and helpers for the delay_sched scheduler.
//   state_t    : FSM encoding (IDLE, RUN, DONE), 2 bits
//   NREQ_DEF   : default number of requesters
//   CBITS_DEF  : default counter / length width
//   len_slice  : extracts requester idx's length field from the packed len bus
// ---------------------------------------------------------------------------
package delay_sched_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int CBITS_DEF = 17;

    // Widest length field and widest packed len bus the helper accepts
    // (16 requesters x 32 bits).
    localparam int LEN_MAX_W = 32;
    localparam int LEN_BUS_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns len[idx*cbits +: cbits], zero-extended to LEN_MAX_W bits.
    // The caller truncates to its own CBITS.
    function automatic logic [LEN_MAX_W-1:0] len_slice(
        input logic [LEN_BUS_W-1:0] len_bus,
        input int unsigned          idx,
        input int unsigned          cbits
    );
        return LEN_MAX_W'(len_bus >> (idx * cbits));
    endfunction

endpackage

// File: rtl/delay_sched_if.sv
// ---------------------------------------------------------------------------
// delay_sched_if
// Requester-side bundle of the delay scheduler.
//   req   : per-requester request level, held until done
//   len   : packed per-requester delay lengths, slice i = len[i*CBITS +: CBITS]
//   gnt   : one-hot grant, zero when idle
//   done  : one-hot single-cycle completion pulse
//   busy  : scheduler not idle
//   abort : one-cycle pulse when a granted requester withdraws mid-run
//           (present only when DELAY_SCHED_ABORT_EN is defined)
// Modports: master (requester side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface delay_sched_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 17
);
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
`ifdef DELAY_SCHED_ABORT_EN
    logic                  abort;

    modport master (output req, len, input gnt, done, busy, abort);
    modport slave  (input req, len, output gnt, done, busy, abort);
`else
    modport master (output req, len, input gnt, done, busy);
    modport slave  (input req, len, output gnt, done, busy);
`endif
endinterface

// File: rtl/delay_rr_pick.sv
// ---------------------------------------------------------------------------
// delay_rr_pick
// Combinational round-robin picker: the winner is the first requester with
// req high, searching ptr, ptr+1, ... modulo NREQ.
//   req    : request vector
//   ptr    : starting search position (must be < NREQ)
//   onehot : one-hot winner, zero when no request
//   idx    : winner index
//   valid  : at least one request present
// ---------------------------------------------------------------------------
module delay_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    logic [PW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] hit;

    // Candidate gi is the requester gi positions after ptr, wrapped.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum           = {1'b0, ptr} + (PW+1)'(gi);
            assign cand_idx[gi]  = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ))
                                                          : sum[PW-1:0];
            assign hit[gi]       = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest offset from ptr wins; scan downward so it is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

    assign onehot = valid ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/delay_sched.sv
// ---------------------------------------------------------------------------
// delay_sched
// Shared delay-timer scheduler. NREQ requesters share one CBITS-wide
// down-counter through a round-robin arbiter. The winner holds gnt while its
// delay of len cycles runs and gets a one-cycle done pulse when it expires.
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset
//   bus : delay_sched_if.slave (req, len in; gnt, done, busy [, abort] out)
// Optional feature macro: DELAY_SCHED_ABORT_EN -- dropping req[w] during RUN
// ends the run without done and pulses bus.abort for one cycle.
// ---------------------------------------------------------------------------
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    delay_sched_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    state_t            state_reg, state_next;
    logic [CBITS-1:0]  cnt_reg,   cnt_next;
    logic [PW-1:0]     ptr_reg,   ptr_next;
    logic [PW-1:0]     win_reg,   win_next;
    logic [NREQ-1:0]   gnt_reg,   gnt_next;

    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [PW-1:0]     win_inc;
    logic [LEN_BUS_W-1:0] len_wide;

    delay_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign len_wide = LEN_BUS_W'(bus.len);
    assign win_inc  = (win_reg == PW'(NREQ - 1)) ? '0 : win_reg + PW'(1);

`ifdef DELAY_SCHED_ABORT_EN
    logic abort_reg, abort_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            win_reg   <= '0;
            gnt_reg   <= '0;
`ifdef DELAY_SCHED_ABORT_EN
            abort_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            gnt_reg   <= gnt_next;
`ifdef DELAY_SCHED_ABORT_EN
            abort_reg <= abort_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        gnt_next   = gnt_reg;
`ifdef DELAY_SCHED_ABORT_EN
        abort_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = RUN;
                    gnt_next   = pick_onehot;
                    win_next   = pick_idx;
                    cnt_next   = CBITS'(len_slice(len_wide, int'(pick_idx), CBITS));
                end
            end
            RUN: begin
`ifdef DELAY_SCHED_ABORT_EN
                // A withdrawn request takes priority over normal expiry.
                if (!bus.req[win_reg]) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    cnt_next   = '0;
                    ptr_next   = win_inc;
                    abort_next = 1'b1;
                end else
`endif
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CBITS'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                gnt_next   = '0;
                ptr_next   = win_inc;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign bus.gnt  = gnt_reg;
    assign bus.done = (state_reg == DONE) ? gnt_reg : '0;
    assign bus.busy = (state_reg != IDLE);
`ifdef DELAY_SCHED_ABORT_EN
    assign bus.abort = abort_reg;
`endif

    // Structural invariants of the grant/done outputs.
    a_gnt_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.done));
    a_done_single:  assert property (@(posedge clk) disable iff (rst)
                                     (bus.done != '0) |=> (bus.done == '0));
    a_done_gnt:     assert property (@(posedge clk) disable iff (rst)
                                     ((bus.done & ~bus.gnt) == '0));
    a_busy_gnt:     assert property (@(posedge clk) disable iff (rst)
                                     bus.busy == (bus.gnt != '0));
    // Counter stops at zero: a RUN with cnt==0 always leaves RUN.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                                     (state_reg == RUN && cnt_reg == '0) |=> (state_reg != RUN));

endmodule

// File: tb/tb_delay_sched.sv
// ---------------------------------------------------------------------------
// tb_delay_sched
// Directed self-checking bench for delay_sched. Inputs change and outputs are
// sampled on the falling clock edge; edge Ek below is the k-th rising edge
// after acceptance (E0 = acceptance edge).
// ---------------------------------------------------------------------------
module tb_delay_sched;
    import delay_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int CBITS = 17;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    delay_sched_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_len(input int i, input logic [CBITS-1:0] v);
        bus.len[i*CBITS +: CBITS] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.len = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++;
        if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
        $display("test_reset done");
    endtask

    // req[0], len=5: done in cycle after E6, idle after E7.
    task automatic test_single();
        logic [NREQ-1:0] gexp, dexp;
        bus.req = 4'b0001;
        set_len(0, 17'd5);
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            gexp = (k <= 6) ? 4'b0001 : 4'b0000;
            dexp = (k == 6) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.gnt !== gexp) begin errors++; $display("FAIL single_gnt k=%0d got=%b exp=%b", k, bus.gnt, gexp); end
            checks++;
            if (bus.done !== dexp) begin errors++; $display("FAIL single_done k=%0d got=%b exp=%b", k, bus.done, dexp); end
            checks++;
            if (bus.busy !== (k <= 6)) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, (k <= 6)); end
            if (k == 6) bus.req[0] = 1'b0;
        end
        $display("test_single done");
    endtask

    // req[2], len=0: done in cycle after E1, gnt clear after E2.
    task automatic test_len0();
        logic [NREQ-1:0] gexp, dexp;
        bus.req = 4'b0100;
        set_len(2, 17'd0);
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            gexp = (k <= 1) ? 4'b0100 : 4'b0000;
            dexp = (k == 1) ? 4'b0100 : 4'b0000;
            checks++;
            if (bus.gnt !== gexp) begin errors++; $display("FAIL len0_gnt k=%0d got=%b exp=%b", k, bus.gnt, gexp); end
            checks++;
            if (bus.done !== dexp) begin errors++; $display("FAIL len0_done k=%0d got=%b exp=%b", k, bus.done, dexp); end
            if (k == 1) bus.req[2] = 1'b0;
        end
        $display("test_len0 done");
    endtask

    // All four requesting, len=3: grants 0,1,2,3,0 with a 6-cycle period.
    task automatic test_round_robin();
        logic [NREQ-1:0] oh, gexp, dexp;
        int w;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 17'd3);
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            w  = r % NREQ;
            oh = 4'b0001 << w;
            for (int k = 0; k <= 5; k++) begin
                @(negedge clk);
                gexp = (k <= 4) ? oh : 4'b0000;
                dexp = (k == 4) ? oh : 4'b0000;
                checks++;
                if (bus.gnt !== gexp) begin errors++; $display("FAIL rr_gnt run=%0d k=%0d got=%b exp=%b", r, k, bus.gnt, gexp); end
                checks++;
                if (bus.done !== dexp) begin errors++; $display("FAIL rr_done run=%0d k=%0d got=%b exp=%b", r, k, bus.done, dexp); end
                if (k == 4) bus.req[w] = 1'b0;
                if (k == 5 && r < 4) bus.req[w] = 1'b1;
            end
        end
        bus.req = '0;
        @(negedge clk);
        $display("test_round_robin done");
    endtask

    // Async reset in RUN at cnt=50; pending req restarts search from 0.
    task automatic test_reset_mid_run();
        bus.req = 4'b0100;            // ptr is 1 here, winner 2
        set_len(2, 17'd100);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL rst_run_gnt got=%b exp=0100", bus.gnt); end
            end
        end
        checks++;
        if (dut.cnt_reg !== 17'd50) begin errors++; $display("FAIL rst_run_cnt got=%0d exp=50", dut.cnt_reg); end
        #2;
        rst     = 1'b1;
        bus.req = 4'b1001;
        set_len(0, 17'd1);
        #1;
        checks++;
        if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL async_gnt got=%b exp=0000", bus.gnt); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", bus.busy); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 4'b0000) begin errors++; $display("FAIL rst_hold_done k=%0d got=%b exp=0000", k, bus.done); end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rst_restart_gnt got=%b exp=0001", bus.gnt); end
        do_reset();
        $display("test_reset_mid_run done");
    endtask

    // Maximum length on requester 1: counter tracks len-k over a long stretch.
    task automatic test_max_len();
        logic [CBITS-1:0] maxv;
        maxv    = '1;
        bus.req = 4'b0010;
        set_len(1, maxv);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 4'b0010 || bus.done !== 4'b0000) begin
                errors++;
                $display("FAIL maxlen_hold k=%0d gnt=%b done=%b exp gnt=0010 done=0000", k, bus.gnt, bus.done);
                break;
            end
        end
        checks++;
        if (dut.cnt_reg !== 17'd128072) begin errors++; $display("FAIL maxlen_cnt got=%0d exp=128072", dut.cnt_reg); end
        do_reset();
        $display("test_max_len done");
    endtask

    // req[3], len=20, req dropped after E10 (cnt=10).
    task automatic test_abort();
        logic [NREQ-1:0] gexp, dexp;
        bus.req = 4'b1000;
        set_len(3, 17'd20);
        for (int k = 0; k <= 10; k++) @(negedge clk);
        checks++;
        if (dut.cnt_reg !== 17'd10) begin errors++; $display("FAIL abort_cnt got=%0d exp=10", dut.cnt_reg); end
        bus.req[3] = 1'b0;
`ifdef DELAY_SCHED_ABORT_EN
        for (int k = 11; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (bus.abort !== (k == 11)) begin errors++; $display("FAIL abort_pulse k=%0d got=%b exp=%b", k, bus.abort, (k == 11)); end
            checks++;
            if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt k=%0d got=%b exp=0000", k, bus.gnt); end
            checks++;
            if (bus.done !== 4'b0000) begin errors++; $display("FAIL abort_done k=%0d got=%b exp=0000", k, bus.done); end
        end
`else
        for (int k = 11; k <= 22; k++) begin
            @(negedge clk);
            gexp = (k <= 21) ? 4'b1000 : 4'b0000;
            dexp = (k == 21) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.gnt !== gexp) begin errors++; $display("FAIL noabort_gnt k=%0d got=%b exp=%b", k, bus.gnt, gexp); end
            checks++;
            if (bus.done !== dexp) begin errors++; $display("FAIL noabort_done k=%0d got=%b exp=%b", k, bus.done, dexp); end
        end
`endif
        $display("test_abort done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_round_robin();
        test_reset_mid_run();
        test_max_len();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
